// File: rtl/math_pkg.sv
// Shared constants and FSM state encoding for the math block family.
package math_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/math_adder_16bit.sv
// 16-bit adder with carry-in; sum[16] is the carry-out.
module math_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [16:0] sum
);

    assign sum = {1'b0, a} + {1'b0, b} + {16'd0, cin};

endmodule

// File: rtl/math_divider_8bit_seq.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock, MSB first.
module math_divider_8bit_seq
    import math_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    state_t            state, state_nxt;
    logic              pending;
    logic [DATA_W-1:0] dividend_q;
    logic [DATA_W-1:0] divisor_q;
    logic [DATA_W:0]   rem_q;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic [DATA_W:0]   r_shift;
    logic [DATA_W:0]   r_next;
    logic [DATA_W-1:0] q_next;
    logic [16:0]       sum;
    logic              r_ge_d;
    logic              last_step;
    logic              zero_div;
    logic              unused_bits;

    // Operands are captured one edge before the FSM leaves IDLE; pending blocks re-acceptance meanwhile.
    assign accept    = (state == IDLE) && !pending && start;
    assign zero_div  = (state == IDLE) && pending && (divisor_q == '0);
    assign last_step = (state == CALC) && (cnt == 3'd7);

    assign r_shift = {rem_q[DATA_W-1:0], dividend_q[DATA_W-1]};

    // Trial subtraction r - d as r + ~d + 1; carry-out set means r >= d.
    math_adder_16bit u_trial_sub (
        .a   ({7'd0, r_shift}),
        .b   (~{8'd0, divisor_q}),
        .cin (1'b1),
        .sum (sum)
    );

    assign r_ge_d      = sum[16];
    assign r_next      = r_ge_d ? sum[DATA_W:0] : r_shift;
    assign q_next      = {dividend_q[DATA_W-2:0], r_ge_d};
    assign unused_bits = ^{sum[15:DATA_W+1], rem_q[DATA_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pending) state_nxt = (divisor_q == '0) ? DONE : CALC;
            CALC: if (cnt == 3'd7) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            pending <= accept;
            if (accept) begin
                dividend_q <= a;
                divisor_q  <= b;
                rem_q      <= '0;
                cnt        <= '0;
            end else if (state == CALC) begin
                rem_q      <= r_next;
                dividend_q <= q_next;
                cnt        <= cnt + 3'd1;
            end
            // Results only change on entry to DONE.
            if (last_step) begin
                quotient    <= q_next;
                remainder   <= r_next[DATA_W-1:0];
                div_by_zero <= 1'b0;
            end else if (zero_div) begin
                quotient    <= 8'hFF;
                remainder   <= dividend_q;
                div_by_zero <= 1'b1;
            end
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule
